// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared signed MAC walks NUM_TAPS taps per sample,
// owning the delay line, a writable coefficient bank and both stream handshakes.
module fir_mac_sequencer #(
   parameter int NUM_TAPS               = 8,
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst_in,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s_data,
   input  logic                                s_last,
   input  logic                                coeff_wr,
   input  logic [$clog2(NUM_TAPS)-1:0]         coeff_addr,
   input  logic [7:0]                          coeff_data,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m_data,
   output logic                                m_last,
   output logic                                busy
);
   localparam int W  = C_S00_AXIS_TDATA_WIDTH;
   localparam int AW = $clog2(NUM_TAPS);
   localparam logic [AW:0]   NT       = (AW+1)'(NUM_TAPS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TAPS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t              state_q, state_d;
   logic signed [W-1:0] x_q     [NUM_TAPS];
   logic signed [W-1:0] x_d     [NUM_TAPS];
   logic signed [7:0]   coeff_q [NUM_TAPS];
   logic signed [7:0]   coeff_d [NUM_TAPS];
   logic [W-1:0]        acc_q, acc_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                last_q, last_d;
   logic [W-1:0]        m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;

   logic signed [W+7:0] prod;
   logic [W-1:0]        mac;
   logic                accept;

   // Only the low W bits of the product matter: accumulation wraps modulo 2^W.
   assign prod   = coeff_q[idx_q] * x_q[idx_q];
   assign mac    = acc_q + prod[W-1:0];
   assign accept = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)            state_d = ACCUM;
         ACCUM:   if (idx_q == LAST_IDX) state_d = OUTPUT;
         OUTPUT:  if (m_ready)           state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state_q == IDLE) && rst_in;
      busy    = (state_q != IDLE) && rst_in;
   end

   always_comb begin
      x_d       = x_q;
      coeff_d   = coeff_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      last_d    = last_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      // A write on the accept cycle lands before the first MAC cycle reads it.
      if (coeff_wr && state_q == IDLE && {1'b0, coeff_addr} < NT)
         coeff_d[coeff_addr] = coeff_data;
      case (state_q)
         IDLE: if (accept) begin
            x_d[0] = s_data;
            for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
            last_d = s_last;
            acc_d  = '0;
            idx_d  = '0;
         end
         ACCUM: begin
            acc_d = mac;
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               m_data_d  = mac;
               m_valid_d = 1'b1;
               m_last_d  = last_q;
            end
         end
         OUTPUT: if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (m_last_q)
               for (int k = 0; k < NUM_TAPS; k++) x_d[k] = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            x_q[k]     <= '0;
            coeff_q[k] <= '0;
         end
         acc_q     <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         x_q       <= x_d;
         coeff_q   <= coeff_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;

endmodule
